// File: rtl/sa_csa_accum_resolve_pkg.sv
// Shared definitions for the carry-save accumulator / resolver slice:
// FSM encodings, default geometry and the chunk-index width helper.
package sa_csa_accum_resolve_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int CHUNK_W_DEF   = 4;
    localparam int NCHUNK        = ACC_WIDTH_DEF / CHUNK_W_DEF;

    // A single-chunk adder still needs a one-bit index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_csa_accum_resolve_csa_4to2.sv
// 4:2 carry-save compressor built from two cascaded 3:2 layers; the shifted
// carries are truncated to WIDTH, so the pair preserves a+b+c+d mod 2^WIDTH.
module sa_csa_4to2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] m1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] m2;

    always_comb begin
        s1    = a ^ b ^ c;
        m1    = (a & b) | (a & c) | (b & c);
        c1    = m1 << 1;
        sum   = s1 ^ c1 ^ d;
        m2    = (s1 & c1) | (s1 & d) | (c1 & d);
        carry = m2 << 1;
    end

endmodule

// File: rtl/sa_csa_accum_resolve.sv
// Burst accumulator held in carry-save form, resolved on the last beat by a
// one-chunk-per-cycle carry-propagate adder and returned over valid/ready.
module sa_csa_accum_resolve
    import sa_csa_accum_resolve_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CHUNK_W   = CHUNK_W_DEF,
    parameter int CNT_W     = 8
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 in_pvld,
    output logic                 in_prdy,
    input  logic [IN_WIDTH-1:0]  in_sum,
    input  logic [IN_WIDTH-1:0]  in_carry,
    input  logic                 in_last,
    output logic                 out_pvld,
    input  logic                 out_prdy,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     out_count
);

    localparam int N_CHUNK = ACC_WIDTH / CHUNK_W;
    localparam int CIDX_W  = idx_w(N_CHUNK);

    state_e               state;
    state_e               state_nxt;
    logic [ACC_WIDTH-1:0] acc_s;
    logic [ACC_WIDTH-1:0] acc_c;
    logic [ACC_WIDTH-1:0] cmp_s;
    logic [ACC_WIDTH-1:0] cmp_c;
    logic [ACC_WIDTH-1:0] ext_sum;
    logic [ACC_WIDTH-1:0] ext_carry;
    logic [CNT_W-1:0]     count;
    logic [CIDX_W-1:0]    chunk_idx;
    logic                 cin;
    logic [CHUNK_W-1:0]   chunk_s;
    logic [CHUNK_W-1:0]   chunk_c;
    logic [CHUNK_W:0]     chunk_sum;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_chunk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_prdy    = (state == ACCUM);
    assign in_fire    = in_pvld && in_prdy;
    assign out_fire   = out_pvld && out_prdy;
    assign last_chunk = (chunk_idx == CIDX_W'(N_CHUNK - 1));
    assign ext_sum    = ACC_WIDTH'(in_sum);
    assign ext_carry  = ACC_WIDTH'(in_carry);

    sa_csa_4to2 #(.WIDTH(ACC_WIDTH)) u_csa (
        .a     (acc_s),
        .b     (acc_c),
        .c     (ext_sum),
        .d     (ext_carry),
        .sum   (cmp_s),
        .carry (cmp_c)
    );

    // Constant-index mux keeps the chunk select free of variable part-selects.
    always_comb begin
        chunk_s = '0;
        chunk_c = '0;
        for (int k = 0; k < N_CHUNK; k++) begin
            if (chunk_idx == CIDX_W'(k)) begin
                chunk_s = acc_s[k*CHUNK_W +: CHUNK_W];
                chunk_c = acc_c[k*CHUNK_W +: CHUNK_W];
            end
        end
        chunk_sum = {1'b0, chunk_s} + {1'b0, chunk_c} + {{CHUNK_W{1'b0}}, cin};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (in_fire && in_last) state_nxt = RESOLVE;
            RESOLVE: if (last_chunk)         state_nxt = OUTPUT;
            OUTPUT:  if (out_fire)           state_nxt = ACCUM;
            default:                         state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            acc_s     <= '0;
            acc_c     <= '0;
            count     <= '0;
            chunk_idx <= '0;
            cin       <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_pvld  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_fire) begin
                        acc_s     <= cmp_s;
                        acc_c     <= cmp_c;
                        count     <= sat_inc(count);
                        chunk_idx <= '0;
                        cin       <= 1'b0;
                    end
                end
                RESOLVE: begin
                    for (int k = 0; k < N_CHUNK; k++) begin
                        if (chunk_idx == CIDX_W'(k)) begin
                            out_data[k*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                        end
                    end
                    // Carry out of the top chunk is dropped: result is mod 2^ACC_WIDTH.
                    cin       <= chunk_sum[CHUNK_W];
                    chunk_idx <= chunk_idx + CIDX_W'(1);
                    if (last_chunk) begin
                        out_pvld  <= 1'b1;
                        out_count <= count;
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        out_pvld <= 1'b0;
                        acc_s    <= '0;
                        acc_c    <= '0;
                        count    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_csa_accum_resolve.sv
// Directed bench for sa_csa_accum_resolve: latency, cross-chunk carry,
// wrap/saturation, backpressure and asynchronous reset mid-resolve.
module tb_sa_csa_accum_resolve;
    import sa_csa_accum_resolve_pkg::*;

    logic        nvdla_core_clk;
    logic        nvdla_core_rstn;
    logic        in_pvld;
    logic        in_prdy;
    logic [7:0]  in_sum;
    logic [7:0]  in_carry;
    logic        in_last;
    logic        out_pvld;
    logic        out_prdy;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    int n_vec;
    int n_err;

    sa_csa_accum_resolve dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_sum          (in_sum),
        .in_carry        (in_carry),
        .in_last         (in_last),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_data        (out_data),
        .out_count       (out_count)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat from a negedge; it is accepted at the following posedge.
    task automatic put(input logic [7:0] s, input logic [7:0] c, input logic l);
        int waited;
        @(negedge nvdla_core_clk);
        waited = 0;
        while (!in_prdy && waited < 50) begin
            @(negedge nvdla_core_clk);
            waited++;
        end
        if (!in_prdy) chk("in_prdy_timeout", 32'(in_prdy), 32'd1);
        in_sum   = s;
        in_carry = c;
        in_last  = l;
        in_pvld  = 1'b1;
        @(posedge nvdla_core_clk);
        #1;
        in_pvld  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int waited;
        waited = 0;
        @(negedge nvdla_core_clk);
        while (!out_pvld && waited < 20) begin
            @(negedge nvdla_core_clk);
            waited++;
        end
        if (!out_pvld) chk("out_pvld_timeout", 32'(out_pvld), 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [15:0] exp_d, input logic [7:0] exp_n);
        wait_out();
        chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
        chk({tag, "_count"}, 32'(out_count), 32'(exp_n));
        chk({tag, "_prdy_low"}, 32'(in_prdy), 32'd0);
        out_prdy = 1'b1;
        @(posedge nvdla_core_clk);
        #1;
        out_prdy = 1'b0;
        chk({tag, "_pvld_drop"}, 32'(out_pvld), 32'd0);
        chk({tag, "_prdy_back"}, 32'(in_prdy), 32'd1);
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        nvdla_core_rstn = 1'b0;
        in_pvld         = 1'b0;
        in_sum          = '0;
        in_carry        = '0;
        in_last         = 1'b0;
        out_prdy        = 1'b0;

        repeat (3) @(negedge nvdla_core_clk);
        chk("rst_pvld", 32'(out_pvld), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_prdy", 32'(in_prdy), 32'd1);
        nvdla_core_rstn = 1'b1;

        // 1: single beat, latency of NCHUNK cycles after the accept edge
        put(8'h0F, 8'h01, 1'b1);
        for (int i = 0; i < NCHUNK; i++) begin
            @(negedge nvdla_core_clk);
            chk("t1_pvld_early", 32'(out_pvld), 32'd0);
            chk("t1_prdy_resolve", 32'(in_prdy), 32'd0);
        end
        @(negedge nvdla_core_clk);
        chk("t1_pvld_on_time", 32'(out_pvld), 32'd1);
        get_result("t1", 16'h0010, 8'd1);

        // 2: carry ripples through chunks 0, 1 and 2
        put(8'hFF, 8'h01, 1'b1);
        get_result("t2", 16'h0100, 8'd1);

        // 3: two beats, a third offered during RESOLVE must be ignored
        put(8'h80, 8'h80, 1'b0);
        put(8'h80, 8'h80, 1'b1);
        @(negedge nvdla_core_clk);
        in_sum   = 8'hFF;
        in_carry = 8'hFF;
        in_last  = 1'b1;
        in_pvld  = 1'b1;
        repeat (2) @(negedge nvdla_core_clk);
        chk("t3_prdy_resolve", 32'(in_prdy), 32'd0);
        in_pvld  = 1'b0;
        in_last  = 1'b0;
        get_result("t3", 16'h0200, 8'd2);

        // 4: 300 x (0xFF + 0xFF) wraps to 153000 mod 65536, count saturates
        for (int i = 0; i < 300; i++) put(8'hFF, 8'hFF, (i == 299));
        get_result("t4", 16'h55A8, 8'hFF);

        // 5: backpressure holds result stable, then the accumulator is clear
        put(8'h10, 8'h20, 1'b1);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            @(negedge nvdla_core_clk);
            chk("t5_hold_pvld", 32'(out_pvld), 32'd1);
            chk("t5_hold_data", 32'(out_data), 32'h0030);
            chk("t5_hold_count", 32'(out_count), 32'd1);
        end
        get_result("t5a", 16'h0030, 8'd1);
        put(8'h01, 8'h00, 1'b1);
        get_result("t5b", 16'h0001, 8'd1);

        // 6: asynchronous reset while chunk 2 is pending
        put(8'h44, 8'h11, 1'b1);
        repeat (3) @(negedge nvdla_core_clk);
        chk("t6_partial", 32'(out_data), 32'h0055);
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t6_rst_pvld", 32'(out_pvld), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_count", 32'(out_count), 32'd0);
        @(negedge nvdla_core_clk);
        nvdla_core_rstn = 1'b1;
        #1;
        chk("t6_prdy_release", 32'(in_prdy), 32'd1);
        put(8'h03, 8'h02, 1'b1);
        get_result("t6", 16'h0005, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
